// File: rtl/branch_history_table_if.sv
// Fetch/execute-facing signal bundle of the branch history table.
// master drives requests (pipeline side), slave is the table itself.
interface branch_history_table_if #(
  parameter int CNT_BITS = 16
);
  logic                flush;
  logic                lookup_en;
  logic [31:0]         lookup_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic                update_en;
  logic [31:0]         update_pc;
  logic                update_taken;
  logic                update_mispred;
  logic                busy;
  logic [CNT_BITS-1:0] mispred_count;

  modport master (
    output flush, lookup_en, lookup_pc, update_en, update_pc, update_taken, update_mispred,
    input  pred_valid, pred_taken, busy, mispred_count
  );
  modport slave (
    input  flush, lookup_en, lookup_pc, update_en, update_pc, update_taken, update_mispred,
    output pred_valid, pred_taken, busy, mispred_count
  );
endinterface

// File: rtl/branch_history_table.sv
// 2-bit saturating branch predictor table with sequenced clear and
// a saturating mispredict counter. One lookup and one update per cycle.
module branch_history_table #(
  parameter int IDX_BITS = 6,
  parameter int CNT_BITS = 16
) (
  input logic               clk,
  input logic               rst,
  branch_history_table_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] clr_idx, clr_nxt;
  logic [1:0]          tbl [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [1:0]          upd_cur, upd_cnt, lk_cnt;
  logic                run_ok, upd_fire, lk_fire;
  logic                pred_valid, pred_taken;
  logic [CNT_BITS-1:0] mis_cnt;

  assign lk_idx  = bus.lookup_pc[IDX_BITS+1:2];
  assign upd_idx = bus.update_pc[IDX_BITS+1:2];

  // Flush wins over anything issued in the same cycle.
  assign run_ok   = (state == RUN) && !bus.flush && !rst;
  assign upd_fire = run_ok && bus.update_en;
  assign lk_fire  = run_ok && bus.lookup_en;

  assign upd_cur = tbl[upd_idx];
  always_comb begin
    upd_cnt = upd_cur;
    if (bus.update_taken) begin
      if (upd_cur != 2'b11) upd_cnt = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_cnt = upd_cur - 2'd1;
    end
  end

  // Same-index update bypasses into the prediction.
  assign lk_cnt = (upd_fire && upd_idx == lk_idx) ? upd_cnt : tbl[lk_idx];

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_idx;
    case (state)
      CLEAR: begin
        if (bus.flush) begin
          clr_nxt = '0;
        end else begin
          clr_nxt = clr_idx + 1'b1;
          if (clr_idx == IDX_BITS'(ENTRIES - 1)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        clr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) tbl[clr_idx] <= 2'b00;
    else if (upd_fire)          tbl[upd_idx] <= upd_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mis_cnt    <= '0;
    end else begin
      pred_valid <= lk_fire;
      if (lk_fire) pred_taken <= lk_cnt[1];
      if (upd_fire && bus.update_mispred && mis_cnt != '1) mis_cnt <= mis_cnt + 1'b1;
    end
  end

  assign bus.pred_valid    = pred_valid;
  assign bus.pred_taken    = pred_taken;
  assign bus.busy          = (state == CLEAR);
  assign bus.mispred_count = mis_cnt;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_BITS+2], bus.lookup_pc[1:0],
                            bus.update_pc[31:IDX_BITS+2], bus.update_pc[1:0]};
endmodule
